axi4lite_regbank_slave: RTL and testbench
=========================================

# axi4lite_regbank_slave

Parametrised AXI4-Lite slave that bridges a host register bus to a word-indexed register bank or block RAM in the video pipeline (MIPI/ISP control, Bayer and colour-correction coefficient banks). It extends the single-outstanding adapter with the following:

- configurable data/address width;
- AW and W channels accepted independently, in either order;
- byte-strobe forwarding;
- out-of-range decode returning SLVERR;
- configurable read latency of the backing memory, with registered, stable read data.

## Interface
Parameters:
- ADDR_W, 32, AXI address width (awaddr/araddr).
- DATA_W, 32, data width; 32 or 64 only.
- NUM_REGS, 64, number of DATA_W words in the bank; index range 0..NUM_REGS-1.
- RD_LAT, 1, memory read latency in cycles, from mem_rd_en to valid mem_rd_data; legal 0..3.
- Derived: STRB_W=DATA_W/8, OFS=log2(STRB_W), IDX_W=max(1,clog2(NUM_REGS)).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- awvalid/awready  in/out  1  write address handshake.
- awaddr  in  ADDR_W  write byte address.
- awprot  in  3  write protection attribute; ignored.
- wvalid/wready  in/out  1  write data handshake.
- wdata  in  DATA_W  write data.
- wstrb  in  STRB_W  byte strobes.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- bresp  out  2  write response: OKAY or SLVERR.
- arvalid/arready  in/out  1  read address handshake.
- araddr  in  ADDR_W  read byte address.
- arprot  in  3  read protection attribute; ignored.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response: OKAY or SLVERR.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wr_idx  out  IDX_W  write word index.
- mem_wr_data  out  DATA_W  write data.
- mem_wr_strb  out  STRB_W  byte enables.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rd_idx  out  IDX_W  read word index.
- mem_rd_data  in  DATA_W  read data, valid RD_LAT cycles after mem_rd_en.

## Operation
Index and range decode:
- idx = addr[ADDR_W-1:OFS]. Low OFS address bits are ignored.
- An access is out of range when idx >= NUM_REGS.

Write FSM (W_COLLECT, W_ISSUE, W_RESP):
- W_COLLECT:
  - awready = ~aw_held and wready = ~w_held.
  - Each handshake captures its payload into a holding register and sets its held flag.
  - When both flags are set (same cycle or different cycles), the FSM moves to W_ISSUE.
- W_ISSUE (one cycle):
  - In range: mem_wr_en=1 with the held idx, data and strobe.
  - Out of range: mem_wr_en stays 0 and bresp=SLVERR is latched.
  - wstrb==0 in range still gives mem_wr_en=1 with strb=0 and OKAY.
- W_RESP:
  - bvalid=1 and bresp held until bready.
  - On handshake, the held flags clear and the FSM returns to W_COLLECT.
  - awready and wready are 0 in W_ISSUE and W_RESP.

Read FSM (R_IDLE, R_WAIT, R_RESP):
- R_IDLE:
  - arready=1.
  - On handshake, idx and the range flag are captured.
  - In range: mem_rd_en=1 on the next cycle and the FSM moves to R_WAIT.
  - Out of range: no mem_rd_en, and the FSM goes straight to R_RESP with rdata=0 and rresp=SLVERR.
- R_WAIT:
  - A counter runs RD_LAT cycles.
  - mem_rd_data is sampled into the rdata register, and the FSM moves to R_RESP.
- R_RESP:
  - rvalid=1. rdata and rresp stay stable until rready.
  - On handshake, the FSM returns to R_IDLE.
  - arready=0 outside R_IDLE.

Channel independence:
- The read and write paths are independent; mem_wr_en and mem_rd_en can be asserted in the same cycle.
- Same-index collisions are resolved by the memory; there is no ordering between channels.

Reset:
- awready=1, wready=1, arready=1.
- bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
- mem_wr_en=0, mem_rd_en=0, mem_wr_idx=0, mem_wr_data=0, mem_wr_strb=0, mem_rd_idx=0.
- Both held flags cleared, both FSMs in their idle state.
- Reset mid-transaction abandons it: no mem strobe and no response is issued afterwards.

## Timing
- Write, AW and W handshaken in cycle 0: mem_wr_en in cycle 1, bvalid in cycle 2. Write throughput is one write per 3 cycles with bready held high.
- Write, W in cycle 0 and AW in cycle 2: mem_wr_en in cycle 3.
- Read, AR handshaken in cycle 0:
  - mem_rd_en in cycle 1;
  - rdata captured at the end of cycle 1+RD_LAT;
  - rvalid in cycle 2+RD_LAT.
- Out-of-range read: rvalid in cycle 1.
- Backpressure on bready/rready: the FSM stalls with its outputs stable; no valid drops early.
- mem_* outputs are registered. The only combinational path from an AXI input to an output is to awready, wready and arready, through the held flags and FSM state.

## Structure
- Package axi4lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - the wr_state_t and rd_state_t enums;
  - a clog2 helper function.
- Sub-module axi4lite_rd_lat_ctr: RD_LAT down-counter that produces the capture pulse. For RD_LAT=0 it captures combinationally in the mem_rd_en cycle.
- The top level contains both FSMs, the holding registers and the decode.

## Test plan
- Aligned write: AW+W in the same cycle, addr 0x10, data 0xDEADBEEF, strb 0xF → mem_wr_en in cycle 1 with idx 4, bvalid in cycle 2, bresp=OKAY.
- Data before address: W (strb 0x3) 3 cycles before AW to 0x08 → exactly one mem_wr_en, idx 2, strb 0x3; awready stays 1 and wready drops after the W handshake.
- Out-of-range access with NUM_REGS=64: write 0x100 → no mem_wr_en, bresp=SLVERR. Read 0x100 → no mem_rd_en, rvalid in cycle 1, rdata=0, rresp=SLVERR.
- Read latency sweep RD_LAT=0..3, read idx 5 returning 0x12345678 → rvalid exactly in cycle 2+RD_LAT; with rready held low for 10 cycles, rdata is stable throughout.
- Concurrency and reset: simultaneous write idx 1 and read idx 2 → both strobes fire in the same cycle. aresetn pulsed in W_ISSUE → no bvalid afterwards, and all outputs return to their reset values.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite register bank slave:
// response codes, FSM states and an elaboration-time log2 helper.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_COLLECT,
      W_ISSUE,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/axi4lite_rd_lat_ctr.sv
// Backing-memory read latency counter; pulses cap in the cycle
// mem_rd_data becomes valid (same cycle as start when RD_LAT is 0).
module axi4lite_rd_lat_ctr #(
   parameter int RD_LAT = 1
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic start,
   output logic cap
);

   logic [1:0] cnt;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= 2'(RD_LAT);
      end else if (cnt != 2'd0) begin
         cnt <= cnt - 2'd1;
      end
   end

   assign cap = (RD_LAT == 0) ? start : (cnt == 2'd1);

endmodule

// File: rtl/axi4lite_regbank_slave.sv
// AXI4-Lite slave bridging to a word-indexed register bank / BRAM,
// with independent AW/W capture, range decode and fixed read latency.
module axi4lite_regbank_slave
   import axi4lite_pkg::*;
#(
   parameter  int ADDR_W   = 32,
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 64,
   parameter  int RD_LAT   = 1,
   localparam int STRB_W   = DATA_W / 8,
   localparam int OFS      = clog2(STRB_W),
   localparam int IDX_W    = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [2:0]        awprot,
   input  logic              wvalid,
   output logic              wready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   output logic              bvalid,
   input  logic              bready,
   output logic [1:0]        bresp,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [2:0]        arprot,
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              mem_wr_en,
   output logic [IDX_W-1:0]  mem_wr_idx,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [STRB_W-1:0] mem_wr_strb,
   output logic              mem_rd_en,
   output logic [IDX_W-1:0]  mem_rd_idx,
   input  logic [DATA_W-1:0] mem_rd_data
);

   function automatic logic oor(input logic [ADDR_W-1:0] a);
      return (a >> OFS) >= ADDR_W'(NUM_REGS);
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a >> OFS);
   endfunction

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic aw_held, w_held, aw_oor;
   logic aw_hs, w_hs, ar_hs, ar_oor, cap;

   logic unused_prot;
   assign unused_prot = ^{awprot, arprot};

   assign awready = (wr_state == W_COLLECT) & ~aw_held;
   assign wready  = (wr_state == W_COLLECT) & ~w_held;
   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid & wready;
   assign bvalid  = (wr_state == W_RESP);

   always_comb begin
      wr_next = wr_state;
      unique case (wr_state)
         W_COLLECT:
            if ((aw_held | aw_hs) & (w_held | w_hs)) wr_next = W_ISSUE;
         W_ISSUE:
            wr_next = W_RESP;
         W_RESP:
            if (bready) wr_next = W_COLLECT;
         default:
            wr_next = W_COLLECT;
      endcase
   end

   // Holding registers double as the registered mem_wr_* outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state    <= W_COLLECT;
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         aw_oor      <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wr_idx  <= '0;
         mem_wr_data <= '0;
         mem_wr_strb <= '0;
         bresp       <= RESP_OKAY;
      end else begin
         wr_state  <= wr_next;
         mem_wr_en <= 1'b0;
         if (aw_hs) begin
            aw_held    <= 1'b1;
            aw_oor     <= oor(awaddr);
            mem_wr_idx <= idx(awaddr);
         end
         if (w_hs) begin
            w_held      <= 1'b1;
            mem_wr_data <= wdata;
            mem_wr_strb <= wstrb;
         end
         if (wr_state == W_COLLECT && wr_next == W_ISSUE)
            mem_wr_en <= aw_hs ? ~oor(awaddr) : ~aw_oor;
         if (wr_state == W_ISSUE)
            bresp <= aw_oor ? RESP_SLVERR : RESP_OKAY;
         if (wr_state == W_RESP && bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
      end
   end

   assign arready = (rd_state == R_IDLE);
   assign ar_hs   = arvalid & arready;
   assign ar_oor  = oor(araddr);
   assign rvalid  = (rd_state == R_RESP);

   always_comb begin
      rd_next = rd_state;
      unique case (rd_state)
         R_IDLE:
            if (arvalid) rd_next = ar_oor ? R_RESP : R_WAIT;
         R_WAIT:
            if (cap) rd_next = R_RESP;
         R_RESP:
            if (rready) rd_next = R_IDLE;
         default:
            rd_next = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state   <= R_IDLE;
         mem_rd_en  <= 1'b0;
         mem_rd_idx <= '0;
         rdata      <= '0;
         rresp      <= RESP_OKAY;
      end else begin
         rd_state  <= rd_next;
         mem_rd_en <= 1'b0;
         if (ar_hs) begin
            mem_rd_idx <= idx(araddr);
            mem_rd_en  <= ~ar_oor;
            if (ar_oor) begin
               rdata <= '0;
               rresp <= RESP_SLVERR;
            end
         end
         if (rd_state == R_WAIT && cap) begin
            rdata <= mem_rd_data;
            rresp <= RESP_OKAY;
         end
      end
   end

   axi4lite_rd_lat_ctr #(
      .RD_LAT (RD_LAT)
   ) u_lat (
      .aclk    (aclk),
      .aresetn (aresetn),
      .start   (mem_rd_en),
      .cap     (cap)
   );

endmodule

// File: tb/tb_axi4lite_regbank_slave.sv
// Directed bench: four slaves with RD_LAT 0..3 share one stimulus;
// instance 1 (default latency) also owns the modelled register bank.
module tb_axi4lite_regbank_slave;

   logic        aclk;
   logic        aresetn;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] awaddr, araddr, wdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;

   logic        awready_o   [4];
   logic        wready_o    [4];
   logic        bvalid_o    [4];
   logic [1:0]  bresp_o     [4];
   logic        arready_o   [4];
   logic        rvalid_o    [4];
   logic [31:0] rdata_o     [4];
   logic [1:0]  rresp_o     [4];
   logic        mem_wr_en_o [4];
   logic [5:0]  mem_wr_idx_o[4];
   logic [31:0] mem_wr_dat_o[4];
   logic [3:0]  mem_wr_stb_o[4];
   logic        mem_rd_en_o [4];
   logic [5:0]  mem_rd_idx_o[4];
   logic [31:0] mem_rd_dat_i[4];

   logic [31:0] bank [64];
   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int n;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < 64; i++)
            bank[i] <= (i == 5) ? 32'h12345678 :
                       (i == 2) ? 32'hAABBCCDD : 32'h0;
      end else if (mem_wr_en_o[1]) begin
         for (int b = 0; b < 4; b++)
            if (mem_wr_stb_o[1][b])
               bank[mem_wr_idx_o[1]][8*b +: 8] <= mem_wr_dat_o[1][8*b +: 8];
      end
      if (mem_wr_en_o[1]) wr_cnt <= wr_cnt + 1;
      if (mem_rd_en_o[1]) rd_cnt <= rd_cnt + 1;
   end

   for (genvar g = 0; g < 4; g++) begin : g_dut
      logic [3:0] en_sh;
      logic [5:0] idx_sh [4];
      logic       vld;
      logic [5:0] vidx;

      always @(posedge aclk) begin
         en_sh     <= {en_sh[2:0], mem_rd_en_o[g]};
         idx_sh[0] <= mem_rd_idx_o[g];
         for (int k = 1; k < 4; k++) idx_sh[k] <= idx_sh[k-1];
      end

      if (g == 0) begin : g_comb
         assign vld  = mem_rd_en_o[g];
         assign vidx = mem_rd_idx_o[g];
      end else begin : g_dly
         assign vld  = en_sh[g-1];
         assign vidx = idx_sh[g-1];
      end

      // Data is only valid in the exact latency cycle; garbage elsewhere.
      assign mem_rd_dat_i[g] = vld ? bank[vidx] : 32'hBAD0BAD0;

      axi4lite_regbank_slave #(
         .RD_LAT (g)
      ) u_dut (
         .aclk        (aclk),
         .aresetn     (aresetn),
         .awvalid     (awvalid),
         .awready     (awready_o[g]),
         .awaddr      (awaddr),
         .awprot      (awprot),
         .wvalid      (wvalid),
         .wready      (wready_o[g]),
         .wdata       (wdata),
         .wstrb       (wstrb),
         .bvalid      (bvalid_o[g]),
         .bready      (bready),
         .bresp       (bresp_o[g]),
         .arvalid     (arvalid),
         .arready     (arready_o[g]),
         .araddr      (araddr),
         .arprot      (arprot),
         .rvalid      (rvalid_o[g]),
         .rready      (rready),
         .rdata       (rdata_o[g]),
         .rresp       (rresp_o[g]),
         .mem_wr_en   (mem_wr_en_o[g]),
         .mem_wr_idx  (mem_wr_idx_o[g]),
         .mem_wr_data (mem_wr_dat_o[g]),
         .mem_wr_strb (mem_wr_stb_o[g]),
         .mem_rd_en   (mem_rd_en_o[g]),
         .mem_rd_idx  (mem_rd_idx_o[g]),
         .mem_rd_data (mem_rd_dat_i[g])
      );
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_awready"}, awready_o[1], 1);
      chk({p, "_wready"}, wready_o[1], 1);
      chk({p, "_arready"}, arready_o[1], 1);
      chk({p, "_bvalid"}, bvalid_o[1], 0);
      chk({p, "_rvalid"}, rvalid_o[1], 0);
      chk({p, "_bresp"}, bresp_o[1], 0);
      chk({p, "_rresp"}, rresp_o[1], 0);
      chk({p, "_rdata"}, rdata_o[1], 0);
      chk({p, "_wr_en"}, mem_wr_en_o[1], 0);
      chk({p, "_rd_en"}, mem_rd_en_o[1], 0);
      chk({p, "_wr_idx"}, mem_wr_idx_o[1], 0);
      chk({p, "_wr_data"}, mem_wr_dat_o[1], 0);
      chk({p, "_wr_strb"}, mem_wr_stb_o[1], 0);
      chk({p, "_rd_idx"}, mem_rd_idx_o[1], 0);
   endtask

   task automatic do_read(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
      arvalid = 1'b1;
      araddr  = a;
      tick();
      arvalid = 1'b0;
      repeat (5) tick();
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("%s_rvalid_L%0d", tag, g), rvalid_o[g], 1);
         chk($sformatf("%s_rdata_L%0d", tag, g), rdata_o[g], exp);
         chk($sformatf("%s_rresp_L%0d", tag, g), rresp_o[g], 0);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0;
      awvalid = 1'b0; awaddr = '0; awprot = '0;
      wvalid  = 1'b0; wdata  = '0; wstrb  = '0;
      bready  = 1'b0;
      arvalid = 1'b0; araddr = '0; arprot = '0;
      rready  = 1'b0;
      repeat (4) tick();
      chk_reset("rst");
      aresetn = 1'b1;
      tick();

      // aligned write, AW and W together
      bready  = 1'b1;
      awvalid = 1'b1; awaddr = 32'h10;
      wvalid  = 1'b1; wdata  = 32'hDEADBEEF; wstrb = 4'hF;
      #1;
      chk("t1_awready", awready_o[1], 1);
      chk("t1_wready", wready_o[1], 1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("t1_wr_en", mem_wr_en_o[1], 1);
      chk("t1_wr_idx", mem_wr_idx_o[1], 4);
      chk("t1_wr_data", mem_wr_dat_o[1], 32'hDEADBEEF);
      chk("t1_wr_strb", mem_wr_stb_o[1], 4'hF);
      chk("t1_issue_awready", awready_o[1], 0);
      chk("t1_bvalid_c1", bvalid_o[1], 0);
      tick();
      chk("t1_bvalid_c2", bvalid_o[1], 1);
      chk("t1_bresp", bresp_o[1], 0);
      chk("t1_wr_en_c2", mem_wr_en_o[1], 0);
      tick();
      chk("t1_bvalid_c3", bvalid_o[1], 0);
      chk("t1_awready_c3", awready_o[1], 1);

      // data three cycles ahead of address
      n = wr_cnt;
      wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'h3;
      tick();
      wvalid = 1'b0;
      chk("t2_wready_held", wready_o[1], 0);
      chk("t2_awready_open", awready_o[1], 1);
      chk("t2_no_wr_en", mem_wr_en_o[1], 0);
      tick();
      tick();
      awvalid = 1'b1; awaddr = 32'h08;
      tick();
      awvalid = 1'b0;
      chk("t2_wr_en", mem_wr_en_o[1], 1);
      chk("t2_wr_idx", mem_wr_idx_o[1], 2);
      chk("t2_wr_strb", mem_wr_stb_o[1], 4'h3);
      chk("t2_wr_data", mem_wr_dat_o[1], 32'h11223344);
      tick();
      chk("t2_bvalid", bvalid_o[1], 1);
      chk("t2_bresp", bresp_o[1], 0);
      tick();
      tick();
      chk("t2_one_strobe", wr_cnt - n, 1);

      // out-of-range write
      n = wr_cnt;
      awvalid = 1'b1; awaddr = 32'h100;
      wvalid  = 1'b1; wdata  = 32'h55555555; wstrb = 4'hF;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("t3_no_wr_en", mem_wr_en_o[1], 0);
      tick();
      chk("t3_bvalid", bvalid_o[1], 1);
      chk("t3_bresp", bresp_o[1], 2'b10);
      tick();
      tick();
      chk("t3_no_strobe", wr_cnt - n, 0);

      // latency sweep, idx 5, rready held low
      arvalid = 1'b1; araddr = 32'h14;
      #1;
      chk("t5_arready", arready_o[1], 1);
      tick();
      arvalid = 1'b0;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("t5_rd_en_L%0d", g), mem_rd_en_o[g], 1);
         chk($sformatf("t5_rd_idx_L%0d", g), mem_rd_idx_o[g], 5);
      end
      for (int c = 1; c <= 14; c++) begin
         for (int g = 0; g < 4; g++) begin
            chk($sformatf("t5_rvalid_L%0d_c%0d", g, c),
                rvalid_o[g], (c >= 2 + g));
            if (c >= 2 + g)
               chk($sformatf("t5_rdata_L%0d_c%0d", g, c),
                   rdata_o[g], 32'h12345678);
         end
         if (c < 14) tick();
      end
      for (int g = 0; g < 4; g++)
         chk($sformatf("t5_rresp_L%0d", g), rresp_o[g], 0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      for (int g = 0; g < 4; g++)
         chk($sformatf("t5_rvalid_done_L%0d", g), rvalid_o[g], 0);

      // out-of-range read
      n = rd_cnt;
      arvalid = 1'b1; araddr = 32'h100;
      tick();
      arvalid = 1'b0;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("t4_rvalid_L%0d", g), rvalid_o[g], 1);
         chk($sformatf("t4_rdata_L%0d", g), rdata_o[g], 0);
         chk($sformatf("t4_rresp_L%0d", g), rresp_o[g], 2'b10);
         chk($sformatf("t4_no_rd_en_L%0d", g), mem_rd_en_o[g], 0);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("t4_rvalid_done", rvalid_o[1], 0);
      tick();
      chk("t4_no_rd_strobe", rd_cnt - n, 0);

      // read back strobe-merged and full writes
      do_read("t6_idx2", 32'h08, 32'hAABB3344);
      do_read("t6_idx4", 32'h10, 32'hDEADBEEF);

      // concurrent write idx 1 and read idx 2
      awvalid = 1'b1; awaddr = 32'h04;
      wvalid  = 1'b1; wdata  = 32'hCAFEF00D; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h08;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("t7_wr_en", mem_wr_en_o[1], 1);
      chk("t7_rd_en", mem_rd_en_o[1], 1);
      chk("t7_wr_idx", mem_wr_idx_o[1], 1);
      chk("t7_rd_idx", mem_rd_idx_o[1], 2);
      rready = 1'b1;
      repeat (6) tick();
      rready = 1'b0;
      chk("t7_rvalid_done", rvalid_o[1], 0);
      chk("t7_bvalid_done", bvalid_o[1], 0);
      do_read("t7_idx1", 32'h04, 32'hCAFEF00D);

      // reset pulsed while in W_ISSUE
      awvalid = 1'b1; awaddr = 32'h0C;
      wvalid  = 1'b1; wdata  = 32'h0BADF00D; wstrb = 4'hF;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("t8_issue_wr_en", mem_wr_en_o[1], 1);
      n = wr_cnt;
      aresetn = 1'b0;
      #1;
      chk_reset("t8_rst");
      aresetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("t8_no_bvalid_c%0d", c), bvalid_o[1], 0);
      end
      chk("t8_no_strobe", wr_cnt - n, 0);
      chk("t8_awready", awready_o[1], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
